// File: rtl/vend_controller.sv
// Vending sequencer: debounces keypad codes, accumulates coin credit, validates selections, runs dispense/change handshakes.
// Latency: key code to press event DEB_CYCLES+1 cycles after it first appears; the event is acted on one cycle later.
// Backpressure: dispense_req/change_valid are held until acked; key events arriving while busy are dropped, not queued.
// Optional build macro VC_TIMEOUT_EN: inactivity timer in CREDIT that returns the credit and adds port timeout_evt.
module vend_controller #(
  parameter int DEB_CYCLES     = 4,
  parameter int COIN_A         = 1,
  parameter int COIN_B         = 2,
  parameter int PRICE0         = 3,
  parameter int PRICE1         = 4,
  parameter int PRICE2         = 5,
  parameter int PRICE3         = 6,
  parameter int MAX_CREDIT     = 15,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_value,
  output logic       dispense_req,
  output logic [1:0] dispense_item,
  input  logic       dispense_ack,
  output logic       change_valid,
  output logic [7:0] change_amount,
  input  logic       change_ack,
  output logic [7:0] credit,
  output logic       busy,
`ifdef VC_TIMEOUT_EN
  output logic       timeout_evt,
`endif
  output logic       err_funds
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_CREDIT   = 2'd1;
  localparam logic [1:0] S_DISPENSE = 2'd2;
  localparam logic [1:0] S_CHANGE   = 2'd3;

  localparam int CW = $clog2(DEB_CYCLES + 1);

  // debouncer state
  logic [3:0]    r_key_q;
  logic [3:0]    r_key_d;
  logic [CW-1:0] r_deb_cnt;
  logic          r_armed;
  logic          r_evt_vld;
  logic [3:0]    r_evt_code;
  logic [CW-1:0] w_deb_nxt;
  logic          w_fire;

  // controller state
  logic [1:0] r_state;
  logic [7:0] r_credit;
  logic       r_disp_req;
  logic [1:0] r_disp_item;
  logic       r_chg_vld;
  logic [7:0] r_chg_amt;
  logic       r_err_funds;

  // key decode
  logic       w_is_coin;
  logic       w_is_sel;
  logic       w_is_cancel;
  logic [7:0] w_coin_amt;
  logic [7:0] w_price;
  logic [1:0] w_sel_idx;
  logic [8:0] w_sum;
  logic [7:0] w_sat;
  logic       w_key_ok;
  logic       w_to_fire;

  // Stable-count of the registered key code; saturates at DEB_CYCLES
  always_comb begin
    w_deb_nxt = '0;
    if (r_key_q != 4'h0) begin
      if (r_key_q != r_key_d)
        w_deb_nxt = CW'(1);
      else if (r_deb_cnt < CW'(DEB_CYCLES))
        w_deb_nxt = r_deb_cnt + CW'(1);
      else
        w_deb_nxt = r_deb_cnt;
    end
  end

  // One event per press: re-armed only after the key has read zero
  assign w_fire = (r_key_q != 4'h0) && r_armed && (w_deb_nxt == CW'(DEB_CYCLES));

  // Debouncer registers and the one-cycle press event
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key_q    <= 4'h0;
      r_key_d    <= 4'h0;
      r_deb_cnt  <= '0;
      r_armed    <= 1'b1;
      r_evt_vld  <= 1'b0;
      r_evt_code <= 4'h0;
    end else begin
      r_key_q    <= key_value;
      r_key_d    <= r_key_q;
      r_deb_cnt  <= w_deb_nxt;
      r_evt_vld  <= w_fire;
      r_evt_code <= r_key_q;
      if (r_key_q == 4'h0)
        r_armed <= 1'b1;
      else if (w_fire)
        r_armed <= 1'b0;
    end
  end

  // Decode the press event into coin / select / cancel
  always_comb begin
    w_is_coin   = 1'b0;
    w_is_sel    = 1'b0;
    w_is_cancel = 1'b0;
    w_coin_amt  = 8'd0;
    w_price     = 8'd0;
    w_sel_idx   = 2'd0;
    case (r_evt_code)
      4'h1: begin w_is_coin = 1'b1; w_coin_amt = 8'(COIN_A); end
      4'h2: begin w_is_coin = 1'b1; w_coin_amt = 8'(COIN_B); end
      4'h3: begin w_is_sel = 1'b1; w_sel_idx = 2'd0; w_price = 8'(PRICE0); end
      4'h4: begin w_is_sel = 1'b1; w_sel_idx = 2'd1; w_price = 8'(PRICE1); end
      4'h5: begin w_is_sel = 1'b1; w_sel_idx = 2'd2; w_price = 8'(PRICE2); end
      4'h6: begin w_is_sel = 1'b1; w_sel_idx = 2'd3; w_price = 8'(PRICE3); end
      4'hA: w_is_cancel = 1'b1;
      default: ;
    endcase
  end

  // Saturating credit add; the overflow above MAX_CREDIT is simply dropped
  assign w_sum    = {1'b0, r_credit} + {1'b0, w_coin_amt};
  assign w_sat    = (w_sum > 9'(MAX_CREDIT)) ? 8'(MAX_CREDIT) : w_sum[7:0];
  assign w_key_ok = r_evt_vld && ((r_state == S_IDLE) || (r_state == S_CREDIT));

`ifdef VC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to_cnt;
  logic          r_timeout_evt;

  // A key event in the same cycle wins over the timeout
  assign w_to_fire = (r_state == S_CREDIT) && !w_key_ok &&
                     (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Inactivity counter: runs only in CREDIT, cleared by every accepted key event
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_to_cnt      <= '0;
      r_timeout_evt <= 1'b0;
    end else begin
      r_timeout_evt <= w_to_fire;
      if ((r_state != S_CREDIT) || w_key_ok || w_to_fire)
        r_to_cnt <= '0;
      else
        r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  assign timeout_evt = r_timeout_evt;
`else
  // No inactivity timer in this build; the parameter is still referenced so both builds share one parameter list
  assign w_to_fire = (TIMEOUT_CYCLES < 0);
`endif

  // Main sequencer: credit accounting and the dispense/change handshakes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_credit    <= 8'd0;
      r_disp_req  <= 1'b0;
      r_disp_item <= 2'd0;
      r_chg_vld   <= 1'b0;
      r_chg_amt   <= 8'd0;
      r_err_funds <= 1'b0;
    end else begin
      r_err_funds <= 1'b0;
      case (r_state)
        S_IDLE, S_CREDIT: begin
          if (w_key_ok) begin
            if (w_is_coin) begin
              r_credit <= w_sat;
              r_state  <= S_CREDIT;
            end else if (w_is_sel) begin
              if (r_credit >= w_price) begin
                r_credit    <= r_credit - w_price;
                r_disp_item <= w_sel_idx;
                r_disp_req  <= 1'b1;
                r_state     <= S_DISPENSE;
              end else begin
                r_err_funds <= 1'b1;
              end
            end else if (w_is_cancel && (r_credit != 8'd0)) begin
              r_chg_amt <= r_credit;
              r_credit  <= 8'd0;
              r_chg_vld <= 1'b1;
              r_state   <= S_CHANGE;
            end
          end else if (w_to_fire) begin
            r_chg_amt <= r_credit;
            r_credit  <= 8'd0;
            r_chg_vld <= 1'b1;
            r_state   <= S_CHANGE;
          end
        end
        S_DISPENSE: begin
          if (dispense_ack) begin
            r_disp_req <= 1'b0;
            if (r_credit != 8'd0) begin
              r_chg_amt <= r_credit;
              r_credit  <= 8'd0;
              r_chg_vld <= 1'b1;
              r_state   <= S_CHANGE;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_CHANGE: begin
          if (change_ack) begin
            r_chg_vld <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dispense_req  = r_disp_req;
  assign dispense_item = r_disp_item;
  assign change_valid  = r_chg_vld;
  assign change_amount = r_chg_amt;
  assign credit        = r_credit;
  assign err_funds     = r_err_funds;
  assign busy          = (r_state == S_DISPENSE) || (r_state == S_CHANGE);

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: table of key presses with expected credit/handshake state,
// plus hand-written sequences for busy-time key discard, async reset mid-change and the optional timeout.
// Expected dispense items and change amounts go through scoreboard queues and are checked when the DUT presents them.
module tb_vend_controller;

  logic       clk;
  logic       reset;
  logic [3:0] key_value;
  logic       dispense_req;
  logic [1:0] dispense_item;
  logic       dispense_ack;
  logic       change_valid;
  logic [7:0] change_amount;
  logic       change_ack;
  logic [7:0] credit;
  logic       busy;
  logic       err_funds;
`ifdef VC_TIMEOUT_EN
  logic       timeout_evt;
`endif

  vend_controller #(
    .DEB_CYCLES    (4),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_value    (key_value),
    .dispense_req (dispense_req),
    .dispense_item(dispense_item),
    .dispense_ack (dispense_ack),
    .change_valid (change_valid),
    .change_amount(change_amount),
    .change_ack   (change_ack),
    .credit       (credit),
    .busy         (busy),
`ifdef VC_TIMEOUT_EN
    .timeout_evt  (timeout_evt),
`endif
    .err_funds    (err_funds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int err_cnt = 0;
  int to_cnt  = 0;

  always @(negedge clk) if (err_funds === 1'b1) err_cnt++;
`ifdef VC_TIMEOUT_EN
  always @(negedge clk) if (timeout_evt === 1'b1) to_cnt++;
`endif

  typedef struct {
    logic [3:0] key;
    int         hold;
    logic [7:0] credit;
    logic       req;
    logic       chg;
    int         err;
    logic       serve;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  logic [1:0] exp_disp [$];
  logic [7:0] exp_chg  [$];

  function automatic vec_t mk(input logic [3:0] k, input int h, input logic [7:0] c,
                              input logic r, input logic g, input int e, input logic s);
    vec_t v;
    v.key = k; v.hold = h; v.credit = c; v.req = r; v.chg = g; v.err = e; v.serve = s;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Hold a key for 'hold' cycles, then release it for three cycles
  task automatic press(input logic [3:0] k, input int hold);
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      key_value = k;
    end
    @(negedge clk);
    key_value = 4'h0;
    repeat (3) @(negedge clk);
  endtask

  task automatic serve_dispense();
    logic [1:0] e;
    int         w;
    e = exp_disp.pop_front();
    w = 0;
    while (dispense_req !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("dispense_req_seen", {31'd0, dispense_req}, 32'd1);
    chk("dispense_item", {30'd0, dispense_item}, {30'd0, e});
    dispense_ack = 1'b1;
    @(negedge clk);
    dispense_ack = 1'b0;
    @(negedge clk);
    chk("dispense_req_dropped", {31'd0, dispense_req}, 32'd0);
  endtask

  task automatic serve_change();
    logic [7:0] e;
    int         w;
    e = exp_chg.pop_front();
    w = 0;
    while (change_valid !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("change_valid_seen", {31'd0, change_valid}, 32'd1);
    chk("change_amount", {24'd0, change_amount}, {24'd0, e});
    change_ack = 1'b1;
    @(negedge clk);
    change_ack = 1'b0;
    @(negedge clk);
    chk("change_valid_dropped", {31'd0, change_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m_prev;
    int         err0;
    string      tag;

    vecs[0]  = mk(4'h1,  2, 8'd0,  0, 0, 0, 0);  // too short to count
    vecs[1]  = mk(4'h1, 10, 8'd1,  0, 0, 0, 0);  // long hold, one event
    vecs[2]  = mk(4'h2,  6, 8'd3,  0, 0, 0, 0);
    vecs[3]  = mk(4'h2,  6, 8'd5,  0, 0, 0, 0);
    vecs[4]  = mk(4'h4,  6, 8'd1,  1, 0, 0, 0);  // product 1, price 4
    vecs[5]  = mk(4'h1,  6, 8'd1,  0, 0, 0, 0);
    vecs[6]  = mk(4'h1,  6, 8'd2,  0, 0, 0, 0);
    vecs[7]  = mk(4'h6,  6, 8'd2,  0, 0, 1, 0);  // price 6 > 2
    vecs[8]  = mk(4'h2,  6, 8'd4,  0, 0, 0, 0);
    vecs[9]  = mk(4'h2,  6, 8'd6,  0, 0, 0, 0);
    vecs[10] = mk(4'h2,  6, 8'd8,  0, 0, 0, 0);
    vecs[11] = mk(4'h2,  6, 8'd10, 0, 0, 0, 0);
    vecs[12] = mk(4'h2,  6, 8'd12, 0, 0, 0, 0);
    vecs[13] = mk(4'h2,  6, 8'd14, 0, 0, 0, 0);
    vecs[14] = mk(4'h2,  6, 8'd15, 0, 0, 0, 0);  // saturates
    vecs[15] = mk(4'h2,  6, 8'd15, 0, 0, 0, 0);
    vecs[16] = mk(4'hA,  6, 8'd0,  0, 1, 0, 1);  // cancel returns 15
    vecs[17] = mk(4'hA,  6, 8'd0,  0, 0, 0, 0);  // cancel with no credit
    vecs[18] = mk(4'h7,  6, 8'd0,  0, 0, 0, 0);  // unmapped key
    vecs[19] = mk(4'h1,  6, 8'd1,  0, 0, 0, 0);
    vecs[20] = mk(4'h2,  6, 8'd3,  0, 0, 0, 0);
    vecs[21] = mk(4'h3,  6, 8'd0,  1, 0, 0, 1);  // exact price, no change
    vecs[22] = mk(4'h2,  6, 8'd2,  0, 0, 0, 0);
    vecs[23] = mk(4'hA,  6, 8'd0,  0, 1, 0, 0);  // change pending for reset test

    reset        = 1'b0;
    key_value    = 4'h0;
    dispense_ack = 1'b0;
    change_ack   = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_credit", {24'd0, credit}, 32'd0);
    chk("rst_dispense_req", {31'd0, dispense_req}, 32'd0);
    chk("rst_dispense_item", {30'd0, dispense_item}, 32'd0);
    chk("rst_change_valid", {31'd0, change_valid}, 32'd0);
    chk("rst_change_amount", {24'd0, change_amount}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err_funds", {31'd0, err_funds}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    m_prev = 8'd0;
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].req) begin
        exp_disp.push_back(2'(vecs[i].key - 4'h3));
        if (vecs[i].credit != 8'd0) exp_chg.push_back(vecs[i].credit);
      end
      if (vecs[i].chg) exp_chg.push_back(m_prev);

      err0 = err_cnt;
      press(vecs[i].key, vecs[i].hold);
      tag = $sformatf("v%0d", i);
      chk({tag, "_credit"}, {24'd0, credit}, {24'd0, vecs[i].credit});
      chk({tag, "_dispense_req"}, {31'd0, dispense_req}, {31'd0, vecs[i].req});
      chk({tag, "_change_valid"}, {31'd0, change_valid}, {31'd0, vecs[i].chg});
      chk({tag, "_busy"}, {31'd0, busy}, {31'd0, vecs[i].req | vecs[i].chg});
      chk({tag, "_err_pulses"}, err_cnt - err0, vecs[i].err);
      m_prev = vecs[i].credit;

      if (i == 4) begin
        // keys while dispensing must be dropped
        err0 = err_cnt;
        press(4'h1, 6);
        press(4'h3, 6);
        press(4'hA, 6);
        chk("busy_credit", {24'd0, credit}, 32'd1);
        chk("busy_dispense_req", {31'd0, dispense_req}, 32'd1);
        chk("busy_change_valid", {31'd0, change_valid}, 32'd0);
        chk("busy_err_pulses", err_cnt - err0, 0);
        vecs[i].serve = 1'b1;
      end

      if (vecs[i].serve) begin
        while (exp_disp.size() > 0) serve_dispense();
        while (exp_chg.size() > 0) serve_change();
        chk({tag, "_served_credit"}, {24'd0, credit}, 32'd0);
        chk({tag, "_served_busy"}, {31'd0, busy}, 32'd0);
        m_prev = 8'd0;
      end
    end

    // change pending from the last vector: check it, then abort it with an async reset
    chk("pre_reset_change_valid", {31'd0, change_valid}, 32'd1);
    chk("pre_reset_change_amount", {24'd0, change_amount}, {24'd0, exp_chg.pop_front()});
    #2;
    reset = 1'b0;
    #1;
    chk("async_change_valid", {31'd0, change_valid}, 32'd0);
    chk("async_change_amount", {24'd0, change_amount}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_credit", {24'd0, credit}, 32'd0);
    chk("async_dispense_req", {31'd0, dispense_req}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);

`ifdef VC_TIMEOUT_EN
    to_cnt = 0;
    press(4'h2, 6);
    press(4'h1, 6);
    chk("to_credit", {24'd0, credit}, 32'd3);
    repeat (40) @(negedge clk);
    chk("to_pulses", to_cnt, 1);
    chk("to_change_valid", {31'd0, change_valid}, 32'd1);
    chk("to_change_amount", {24'd0, change_amount}, 32'd3);
    chk("to_credit_cleared", {24'd0, credit}, 32'd0);
    change_ack = 1'b1;
    @(negedge clk);
    change_ack = 1'b0;
    @(negedge clk);
    chk("to_idle", {31'd0, busy}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
